vmu_bus_bridge: RTL and testbench

- Sits directly downstream of the vector memory unit.
- Accepts one line-wide vector_mem_req (REQ_DATA_WIDTH bits) at a time and serialises it into BUS_WIDTH-wide word transfers on the CPU data bus (strobe/ack protocol).
- For loads, it gathers the returned words into one line and returns it to the VMU as a ticketed vector_mem_resp.
- Its request handshake drives the VMU's cache_ready_i; its response drives mem_resp_valid_i / mem_resp_i.

---
 rtl/vmu_bus_bridge_pkg.sv | 47 ++++
 rtl/vmu_bus_bridge.sv | 120 ++++++++++++
 tb/tb_vmu_bus_bridge.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vmu_bus_bridge_pkg.sv
// Shared types for the vector memory unit and its CPU-bus bridge: the
// ticketed line-wide request/response records, the load/store opcodes and
// the bridge FSM state encoding.
package vmu_bus_bridge_pkg;

  localparam int vmu_req_data_width_c = 256;
  localparam int vmu_bus_width_c      = 32;
  localparam int vmu_addr_width_c     = 32;
  localparam int vmu_vector_lanes_c   = 8;
  localparam int vmu_ticket_width_c   = $clog2(vmu_vector_lanes_c) + 1;
  localparam int vmu_microop_width_c  = 4;

  localparam logic [vmu_microop_width_c-1:0] opcode_vload_c  = 4'h1;
  localparam logic [vmu_microop_width_c-1:0] opcode_vstore_c = 4'h2;

  // Number of bus words that make up one vector line.
  localparam int vmu_bus_beats_c   = vmu_req_data_width_c / vmu_bus_width_c;
  // Byte-offset bits within one line.
  localparam int vmu_line_offset_c = $clog2(vmu_req_data_width_c / 8);

  typedef struct packed {
    logic [vmu_addr_width_c-1:0]     address;
    logic [vmu_microop_width_c-1:0]  microop;
    logic [vmu_ticket_width_c-1:0]   ticket;
    logic [vmu_req_data_width_c-1:0] data;
  } vector_mem_req;

  typedef struct packed {
    logic [vmu_ticket_width_c-1:0]   ticket;
    logic [vmu_req_data_width_c-1:0] data;
  } vector_mem_resp;

  typedef enum logic [1:0] {
    IDLE,
    STB,
    WAIT,
    RESP
  } vmu_bridge_state_e;

  // Align a byte address down to the start of its vector line.
  function automatic logic [vmu_addr_width_c-1:0] line_base(
    input logic [vmu_addr_width_c-1:0] addr
  );
    return {addr[vmu_addr_width_c-1:vmu_line_offset_c], {vmu_line_offset_c{1'b0}}};
  endfunction

endpackage

// File: rtl/vmu_bus_bridge.sv
// Bridge between the vector memory unit and the CPU data bus. One line-wide
// request is split into BEATS word transfers (strobe/ack); load words are
// gathered back into a line and returned as a single ticketed response.
module vmu_bus_bridge
  import vmu_bus_bridge_pkg::*;
#(
  parameter int REQ_DATA_WIDTH = vmu_req_data_width_c,
  parameter int BUS_WIDTH      = vmu_bus_width_c,
  parameter int ADDR_WIDTH     = vmu_addr_width_c
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   idle_o,
  input  logic                   mem_req_valid_i,
  input  vector_mem_req          mem_req_i,
  output logic                   mem_req_ready_o,
  output logic                   mem_resp_valid_o,
  output vector_mem_resp         mem_resp_o,
  output logic                   mem_resp_err_o,
  output logic                   bus_stb_o,
  output logic [ADDR_WIDTH-1:0]  bus_addr_o,
  output logic                   bus_we_o,
  output logic [BUS_WIDTH/8-1:0] bus_ben_o,
  output logic [BUS_WIDTH-1:0]   bus_wdata_o,
  input  logic [BUS_WIDTH-1:0]   bus_rdata_i,
  input  logic                   bus_ack_i,
  input  logic                   bus_err_i
);

  localparam int BEATS     = REQ_DATA_WIDTH / BUS_WIDTH;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BUS_BYTES = BUS_WIDTH / 8;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  vmu_bridge_state_e           state_q;
  logic [BEAT_W-1:0]           beat_q;
  logic                        err_q;
  logic                        is_ld_q;
  logic [vmu_ticket_width_c-1:0] ticket_q;
  logic [REQ_DATA_WIDTH-1:0]   data_q;
  logic [REQ_DATA_WIDTH-1:0]   line_q;

  // Ready is a pure decode of the state so the VMU sees it without waiting
  // on its own valid.
  assign idle_o           = (state_q == IDLE);
  assign mem_req_ready_o  = (state_q == IDLE);
  assign mem_resp_o       = '{ticket: ticket_q, data: line_q};
  assign mem_resp_err_o   = err_q;

  // FSM plus datapath: every state bit and bus output is a flop.
  // NOTE: non-blocking assignments throughout, so every flop samples the
  // pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      beat_q           <= '0;
      err_q            <= 1'b0;
      is_ld_q          <= 1'b0;
      ticket_q         <= '0;
      data_q           <= '0;
      line_q           <= '0;
      mem_resp_valid_o <= 1'b0;
      bus_stb_o        <= 1'b0;
      bus_addr_o       <= '0;
      bus_we_o         <= 1'b0;
      bus_ben_o        <= '0;
      bus_wdata_o      <= '0;
    end else begin
      bus_stb_o        <= 1'b0;
      mem_resp_valid_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mem_req_valid_i) begin
            is_ld_q     <= (mem_req_i.microop == opcode_vload_c);
            ticket_q    <= mem_req_i.ticket;
            data_q      <= mem_req_i.data;
            beat_q      <= '0;
            err_q       <= 1'b0;
            bus_addr_o  <= line_base(mem_req_i.address);
            bus_we_o    <= (mem_req_i.microop != opcode_vload_c);
            bus_ben_o   <= '1;
            bus_wdata_o <= mem_req_i.data[BUS_WIDTH-1:0];
            bus_stb_o   <= 1'b1;
            state_q     <= STB;
          end
        end
        STB: begin
          state_q <= WAIT;
        end
        WAIT: begin
          // An error terminates the beat like an ack and wins over it.
          if (bus_ack_i || bus_err_i) begin
            if (is_ld_q) begin
              line_q[int'(beat_q) * BUS_WIDTH +: BUS_WIDTH] <= bus_err_i ? '0 : bus_rdata_i;
            end
            if (bus_err_i) begin
              err_q <= 1'b1;
            end
            if (beat_q != LAST_BEAT) begin
              beat_q      <= beat_q + 1'b1;
              bus_addr_o  <= bus_addr_o + ADDR_WIDTH'(BUS_BYTES);
              bus_wdata_o <= data_q[(int'(beat_q) + 1) * BUS_WIDTH +: BUS_WIDTH];
              bus_stb_o   <= 1'b1;
              state_q     <= STB;
            end else if (is_ld_q) begin
              mem_resp_valid_o <= 1'b1;
              state_q          <= RESP;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vmu_bus_bridge.sv
// Directed bench for vmu_bus_bridge: a table of single-request transactions
// plus hand-written reset-abort and back-to-back sequences. A bus responder
// acks each strobe after a configurable latency; a negedge monitor logs
// strobes, responses and acceptances with the edge number they occur on.
module tb_vmu_bus_bridge;
  import vmu_bus_bridge_pkg::*;

  localparam int W     = vmu_bus_width_c;
  localparam int BEATS = vmu_bus_beats_c;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           idle_o;
  logic           mem_req_valid_i = 1'b0;
  vector_mem_req  mem_req_i = '0;
  logic           mem_req_ready_o;
  logic           mem_resp_valid_o;
  vector_mem_resp mem_resp_o;
  logic           mem_resp_err_o;
  logic           bus_stb_o;
  logic [31:0]    bus_addr_o;
  logic           bus_we_o;
  logic [3:0]     bus_ben_o;
  logic [31:0]    bus_wdata_o;
  logic [31:0]    bus_rdata_i = '0;
  logic           bus_ack_i = 1'b0;
  logic           bus_err_i = 1'b0;

  vmu_bus_bridge dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .idle_o           (idle_o),
    .mem_req_valid_i  (mem_req_valid_i),
    .mem_req_i        (mem_req_i),
    .mem_req_ready_o  (mem_req_ready_o),
    .mem_resp_valid_o (mem_resp_valid_o),
    .mem_resp_o       (mem_resp_o),
    .mem_resp_err_o   (mem_resp_err_o),
    .bus_stb_o        (bus_stb_o),
    .bus_addr_o       (bus_addr_o),
    .bus_we_o         (bus_we_o),
    .bus_ben_o        (bus_ben_o),
    .bus_wdata_o      (bus_wdata_o),
    .bus_rdata_i      (bus_rdata_i),
    .bus_ack_i        (bus_ack_i),
    .bus_err_i        (bus_err_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Edge counter: after posedge number E, cyc == E.
  int cyc = 0;
  initial forever begin
    @(posedge clk_i);
    cyc = cyc + 1;
  end

  // Bus responder configuration.
  int          rsp_lat      = 1;
  int          rsp_err_beat = 99;
  logic [31:0] rsp_rbase    = '0;
  int          rsp_beat     = 0;

  // Responder: ack (and err on the chosen beat) is sampled rsp_lat edges
  // after the strobe edge; rdata is rbase + running beat index.
  initial begin
    int k;
    forever begin
      @(negedge clk_i);
      if (bus_stb_o === 1'b1 && rst_i === 1'b0) begin
        k = rsp_beat;
        rsp_beat++;
        repeat (rsp_lat) @(posedge clk_i);
        #1;
        bus_ack_i   = 1'b1;
        bus_err_i   = (k == rsp_err_beat);
        bus_rdata_i = rsp_rbase + 32'(k);
        @(posedge clk_i);
        #1;
        bus_ack_i   = 1'b0;
        bus_err_i   = 1'b0;
        bus_rdata_i = '0;
      end
    end
  end

  // Monitor logs.
  int             n_stb = 0;
  int             stb_edge [32];
  logic [31:0]    log_addr [32];
  logic           log_we   [32];
  logic [3:0]     log_ben  [32];
  logic [31:0]    log_wdata[32];
  int             resp_cnt   = 0;
  int             resp_edge  = 0;
  vector_mem_resp resp_seen  = '0;
  logic           resp_err   = 1'b0;
  int             acc_n      = 0;
  int             stable_bad = 0;

  initial forever begin
    @(negedge clk_i);
    if (mem_req_valid_i && mem_req_ready_o) acc_n++;
    if (bus_stb_o) begin
      if (n_stb < 32) begin
        stb_edge[n_stb]  = cyc + 1;
        log_addr[n_stb]  = bus_addr_o;
        log_we[n_stb]    = bus_we_o;
        log_ben[n_stb]   = bus_ben_o;
        log_wdata[n_stb] = bus_wdata_o;
      end
      n_stb++;
    end else if (!idle_o && !mem_resp_valid_o && n_stb > 0 && n_stb <= 32) begin
      if (bus_addr_o !== log_addr[n_stb-1] || bus_we_o !== log_we[n_stb-1] ||
          bus_ben_o !== log_ben[n_stb-1] || bus_wdata_o !== log_wdata[n_stb-1])
        stable_bad++;
    end
    if (mem_resp_valid_o) begin
      resp_cnt++;
      resp_edge = cyc + 1;
      resp_seen = mem_resp_o;
      resp_err  = mem_resp_err_o;
    end
  end

  task automatic clear_logs();
    n_stb = 0; resp_cnt = 0; acc_n = 0; stable_bad = 0; rsp_beat = 0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [3:0]  microop;
    logic [3:0]  ticket;
    logic [31:0] seed;
    int          lat;
    int          err_beat;
    logic [31:0] rbase;
    logic [31:0] exp_base;
    logic        exp_we;
    logic        exp_resp;
    logic        exp_err;
    int          exp_resp_off;
    int          exp_ready_off;
  } vec_t;

  vec_t vecs[7];

  function automatic vector_mem_req make_req(input logic [31:0] addr, input logic [3:0] op,
                                             input logic [3:0] tk, input logic [31:0] seed);
    vector_mem_req r;
    r.address = addr;
    r.microop = op;
    r.ticket  = tk;
    for (int k = 0; k < BEATS; k++) r.data[k*W +: W] = seed + 32'(k);
    return r;
  endfunction

  task automatic run_vec(input vec_t v);
    int          t0;
    int          ready_edge;
    bit          got;
    logic [255:0] exp_line;
    clear_logs();
    rsp_lat = v.lat; rsp_err_beat = v.err_beat; rsp_rbase = v.rbase;
    t0 = 0; ready_edge = 0;
    @(posedge clk_i); #1;
    mem_req_valid_i = 1'b1;
    mem_req_i = make_req(v.addr, v.microop, v.ticket, v.seed);
    got = 0;
    for (int g = 0; g < 50 && !got; g++) begin
      @(negedge clk_i);
      if (mem_req_ready_o) begin got = 1; t0 = cyc + 1; end
    end
    check({v.name, "/accept"}, 256'(got), 256'(1));
    @(posedge clk_i); #1;
    mem_req_valid_i = 1'b0;
    got = 0;
    for (int g = 0; g < 200 && !got; g++) begin
      @(negedge clk_i);
      if (idle_o) begin got = 1; ready_edge = cyc + 1; end
    end
    check({v.name, "/ready_edge"}, 256'(ready_edge), 256'(t0 + v.exp_ready_off));
    repeat (4) @(negedge clk_i);
    check({v.name, "/n_stb"}, 256'(n_stb), 256'(BEATS));
    for (int k = 0; k < BEATS && k < n_stb; k++) begin
      check($sformatf("%s/addr%0d", v.name, k), 256'(log_addr[k]), 256'(v.exp_base + 32'(4*k)));
      check($sformatf("%s/we%0d", v.name, k), 256'(log_we[k]), 256'(v.exp_we));
      check($sformatf("%s/ben%0d", v.name, k), 256'(log_ben[k]), 256'(4'hF));
      check($sformatf("%s/wdata%0d", v.name, k), 256'(log_wdata[k]), 256'(v.seed + 32'(k)));
      check($sformatf("%s/stb_edge%0d", v.name, k), 256'(stb_edge[k]), 256'(t0 + 1 + k*(1 + v.lat)));
    end
    check({v.name, "/stable"}, 256'(stable_bad), 256'(0));
    check({v.name, "/resp_cnt"}, 256'(resp_cnt), 256'(v.exp_resp));
    if (v.exp_resp) begin
      for (int k = 0; k < BEATS; k++)
        exp_line[k*W +: W] = (k == v.err_beat) ? 32'h0 : v.rbase + 32'(k);
      check({v.name, "/resp_edge"}, 256'(resp_edge), 256'(t0 + v.exp_resp_off));
      check({v.name, "/ticket"}, 256'(resp_seen.ticket), 256'(v.ticket));
      check({v.name, "/line"}, resp_seen.data, exp_line);
      check({v.name, "/err"}, 256'(resp_err), 256'(v.exp_err));
    end
  endtask

  initial begin
    int t1, t2;
    bit got;
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int t1, t2;
    bit got;

    vecs[0] = '{"load_zw",  32'h1000_0014, opcode_vload_c,  4'd5,  32'h0,         1, 99, 32'hA000_0000,
                32'h1000_0000, 1'b0, 1'b1, 1'b0, 17, 18};
    vecs[1] = '{"store_zw", 32'h2000_0040, opcode_vstore_c, 4'd3,  32'h0,         1, 99, 32'h0,
                32'h2000_0040, 1'b1, 1'b0, 1'b0, 0,  17};
    vecs[2] = '{"load_lat3", 32'h3000_0000, opcode_vload_c, 4'd7,  32'h0,         3, 99, 32'hB000_0000,
                32'h3000_0000, 1'b0, 1'b1, 1'b0, 33, 34};
    vecs[3] = '{"load_err3", 32'h4000_003F, opcode_vload_c, 4'd9,  32'h0,         1, 3,  32'hC000_0000,
                32'h4000_0020, 1'b0, 1'b1, 1'b1, 17, 18};
    vecs[4] = '{"load_top", 32'hFFFF_FFE7, opcode_vload_c,  4'd15, 32'h0,         2, 99, 32'h1234_0000,
                32'hFFFF_FFE0, 1'b0, 1'b1, 1'b0, 25, 26};
    vecs[5] = '{"store_op7", 32'h5000_001F, 4'h7,           4'd1,  32'hDEAD_0000, 1, 99, 32'h0,
                32'h5000_0000, 1'b1, 1'b0, 1'b0, 0,  17};
    vecs[6] = '{"load_err7", 32'h6000_0000, opcode_vload_c, 4'd4,  32'h0,         1, 7,  32'h7700_0000,
                32'h6000_0000, 1'b0, 1'b1, 1'b1, 17, 18};

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst/idle", 256'(idle_o), 256'(1));
    check("rst/ready", 256'(mem_req_ready_o), 256'(1));
    check("rst/stb", 256'(bus_stb_o), 256'(0));
    check("rst/resp_valid", 256'(mem_resp_valid_o), 256'(0));
    check("rst/bus", 256'({bus_addr_o, bus_we_o, bus_ben_o, bus_wdata_o}), 256'(0));
    check("rst/resp", 256'(mem_resp_o), 256'(0));
    check("rst/err", 256'(mem_resp_err_o), 256'(0));

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset while waiting on beat 4; the late ack must be ignored.
    clear_logs();
    rsp_lat = 2; rsp_err_beat = 99; rsp_rbase = 32'h9000_0000;
    @(posedge clk_i); #1;
    mem_req_valid_i = 1'b1;
    mem_req_i = make_req(32'h7000_0000, opcode_vload_c, 4'd6, 32'h0);
    @(posedge clk_i); #1;
    mem_req_valid_i = 1'b0;
    got = 0;
    for (int g = 0; g < 100 && !got; g++) begin
      @(negedge clk_i);
      if (n_stb >= 5) got = 1;
    end
    check("rst_mid/reach_beat4", 256'(got), 256'(1));
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (30) @(negedge clk_i);
    check("rst_mid/n_stb", 256'(n_stb), 256'(5));
    check("rst_mid/resp_cnt", 256'(resp_cnt), 256'(0));
    check("rst_mid/idle", 256'(idle_o), 256'(1));
    check("rst_mid/ready", 256'(mem_req_ready_o), 256'(1));
    check("rst_mid/bus", 256'({bus_stb_o, bus_addr_o, bus_we_o, bus_ben_o, bus_wdata_o}), 256'(0));
    check("rst_mid/resp", 256'({mem_resp_valid_o, mem_resp_err_o, mem_resp_o}), 256'(0));

    // Back-to-back: valid held across a store then a load.
    clear_logs();
    rsp_lat = 1; rsp_err_beat = 99; rsp_rbase = 32'hD000_0000;
    t1 = 0; t2 = 0;
    @(posedge clk_i); #1;
    mem_req_valid_i = 1'b1;
    mem_req_i = make_req(32'h8000_0000, opcode_vstore_c, 4'd1, 32'h100);
    @(negedge clk_i);
    t1 = cyc + 1;
    @(posedge clk_i); #1;
    mem_req_i = make_req(32'h8000_0100, opcode_vload_c, 4'd2, 32'h0);
    repeat (3) @(negedge clk_i);
    check("b2b/ready_low_busy", 256'(mem_req_ready_o), 256'(0));
    got = 0;
    for (int g = 0; g < 100 && !got; g++) begin
      @(negedge clk_i);
      if (mem_req_ready_o) begin got = 1; t2 = cyc + 1; end
    end
    check("b2b/second_accept_edge", 256'(t2), 256'(t1 + 17));
    @(posedge clk_i); #1;
    mem_req_valid_i = 1'b0;
    repeat (25) @(negedge clk_i);
    check("b2b/acc_n", 256'(acc_n), 256'(2));
    check("b2b/n_stb", 256'(n_stb), 256'(2*BEATS));
    check("b2b/resp_cnt", 256'(resp_cnt), 256'(1));
    check("b2b/resp_edge", 256'(resp_edge), 256'(t2 + 17));
    check("b2b/ticket", 256'(resp_seen.ticket), 256'(2));
    check("b2b/word0", 256'(resp_seen.data[31:0]), 256'(32'hD000_0008));
    check("b2b/addr8", 256'(log_addr[8]), 256'(32'h8000_0100));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
